// File: rtl/cnn_buffer_sched_pkg.sv
// Shared definitions for the CNN line-buffer layer sequencer: widths, FSM state encoding
// and the tile-depth helper.
package cnn_buffer_sched_pkg;

  localparam int BUFFER_DEPTH = 8;
  localparam int BUFFER_WIDTH = 32;
  localparam int KW           = 3;
  localparam int SW           = 2;
  localparam int HW           = 10;
  localparam int CW           = 8;
  localparam int NW           = 16;
  localparam int FW           = $clog2(BUFFER_WIDTH);
  localparam int DW           = $clog2(BUFFER_DEPTH);
  localparam int RW           = HW + 1;

  typedef enum logic [2:0] {
    SCHED_IDLE,
    SCHED_CALC,
    SCHED_START,
    SCHED_RUN,
    SCHED_DRAIN,
    SCHED_FIN,
    SCHED_NEXT,
    SCHED_DONE
  } sched_state_t;

  // Returns T-1 where T = min(BUFFER_DEPTH, fmap_h - row); a row at or past the map end yields 0.
  function automatic logic [DW-1:0] tile_depth(input logic [HW-1:0] fmap_h,
                                               input logic [RW-1:0] row);
    logic [RW-1:0] rem;
    rem = {1'b0, fmap_h} - row;
    if (row >= {1'b0, fmap_h})
      return '0;
    else if (rem >= RW'(BUFFER_DEPTH))
      return DW'(BUFFER_DEPTH - 1);
    else
      return DW'(rem - RW'(1));
  endfunction

endpackage

// File: rtl/cnn_buffer_sched_tile_calc.sv
// Iterative row-step calculator: step = outputs_per_full_tile * stride, found by
// repeated addition (at most BUFFER_DEPTH cycles, no divider).
module cnn_tile_calc
  import cnn_buffer_sched_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic [KW-1:0] i_kh,
  input  logic [SW-1:0] i_stride,
  output logic          o_busy,
  output logic [RW-1:0] o_step
);

  logic [RW-1:0] r_acc;
  logic [RW-1:0] r_step;
  logic [SW-1:0] r_stride;
  logic          r_busy;
  logic [RW-1:0] w_acc_nxt;
  logic          w_fits;

  assign w_acc_nxt = r_acc + RW'(r_stride);
  assign w_fits    = (w_acc_nxt <= RW'(BUFFER_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_step   <= '0;
      r_stride <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_acc    <= RW'(i_kh);
      r_step   <= '0;
      r_stride <= i_stride;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      // The final pass adds one more stride for the window that starts the next tile.
      r_step <= r_step + RW'(r_stride);
      if (w_fits)
        r_acc <= w_acc_nxt;
      else
        r_busy <= 1'b0;
    end
  end

  assign o_busy = r_busy;
  assign o_step = r_step;

endmodule

// File: rtl/cnn_buffer_sched.sv
// Layer-level sequencer for the CNN line buffer: splits a layer into row tiles per input
// channel, drives the buffer's static configuration and the req/req_final pulses.
module cnn_buffer_sched
  import cnn_buffer_sched_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [KW-1:0] cfg_kw,
  input  logic [KW-1:0] cfg_kh,
  input  logic [SW-1:0] cfg_stride,
  input  logic [KW-1:0] cfg_pad,
  input  logic [FW-1:0] cfg_fmap_w,
  input  logic [HW-1:0] cfg_fmap_h,
  input  logic [CW-1:0] cfg_ch,
  input  logic          abort,
  output logic [KW-1:0] kernel_width_o,
  output logic [KW-1:0] kernel_height_o,
  output logic [SW-1:0] stride_o,
  output logic [KW-1:0] padding_o,
  output logic [FW-1:0] buffer_width_o,
  output logic [DW-1:0] buffer_depth_o,
  output logic          buf_req,
  output logic          buf_req_final,
  input  logic          window_valid,
  input  logic          window_finish,
  input  logic          window_stall,
  output logic [HW-1:0] tile_row_o,
  output logic [CW-1:0] tile_ch_o,
  output logic [NW-1:0] win_cnt,
  output logic          busy,
  output logic          done,
  output logic          cfg_err,
  output sched_state_t  dbg_state
);

  // Handshake: a descriptor transfers on the cycle where cfg_valid & cfg_ready are both high;
  // cfg_ready is high only in IDLE and the master holds the fields stable while cfg_valid is high.

  sched_state_t  r_state;
  sched_state_t  w_state_nxt;
  logic [KW-1:0] r_kw, r_kh, r_pad;
  logic [SW-1:0] r_stride;
  logic [FW-1:0] r_fmap_w, r_buf_w;
  logic [HW-1:0] r_fmap_h;
  logic [CW-1:0] r_ch, r_tile_ch, w_ch_nxt;
  logic [DW-1:0] r_buf_d;
  logic [RW-1:0] r_tile_row, w_row_nxt;
  logic [NW-1:0] r_win_cnt;
  logic          r_cfg_err, r_aborted;
  logic          w_accept, w_bad, w_take, w_last, w_final_ch, w_win_inc;
  logic          w_calc_busy;
  logic [RW-1:0] w_step;

  assign w_accept = (r_state == SCHED_IDLE) & cfg_valid;
  assign w_bad    = (cfg_kw == '0) | (cfg_kh == '0) | (cfg_stride == '0) |
                    (int'(cfg_kh) > BUFFER_DEPTH) |
                    ((cfg_pad != '0) & (int'(cfg_fmap_h) > BUFFER_DEPTH));
  assign w_take   = w_accept & ~w_bad;

  // r_buf_d holds T-1 of the current tile, so the last-tile test reuses it.
  assign w_last     = (r_tile_row + RW'(r_buf_d) + RW'(1)) >= {1'b0, r_fmap_h};
  assign w_final_ch = (r_tile_ch == r_ch - CW'(1));
  assign w_win_inc  = (r_state != SCHED_IDLE) & window_valid & ~window_stall &
                      (r_win_cnt != '1);

  cnn_tile_calc u_calc (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_take),
    .i_kh     (cfg_kh),
    .i_stride (cfg_stride),
    .o_busy   (w_calc_busy),
    .o_step   (w_step)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_tile_row;
    w_ch_nxt    = r_tile_ch;
    case (r_state)
      SCHED_IDLE:  if (w_take) w_state_nxt = SCHED_CALC;
      SCHED_CALC:  if (abort) w_state_nxt = SCHED_IDLE;
                   else if (!w_calc_busy) w_state_nxt = SCHED_START;
      SCHED_START: w_state_nxt = abort ? SCHED_IDLE : SCHED_RUN;
      SCHED_RUN:   if (abort || window_finish) w_state_nxt = abort ? SCHED_FIN : SCHED_DRAIN;
      SCHED_DRAIN: if (abort || !window_stall) w_state_nxt = SCHED_FIN;
      SCHED_FIN:   w_state_nxt = (abort || r_aborted) ? SCHED_IDLE : SCHED_NEXT;
      SCHED_NEXT: begin
        if (abort) begin
          w_state_nxt = SCHED_IDLE;
        end else if (w_last && w_final_ch) begin
          w_state_nxt = SCHED_DONE;
        end else if (w_last) begin
          w_row_nxt   = '0;
          w_ch_nxt    = r_tile_ch + CW'(1);
          w_state_nxt = SCHED_START;
        end else begin
          w_row_nxt   = r_tile_row + w_step;
          w_state_nxt = SCHED_START;
        end
      end
      SCHED_DONE:  w_state_nxt = SCHED_IDLE;
      default:     w_state_nxt = SCHED_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= SCHED_IDLE;
      r_kw       <= '0;
      r_kh       <= '0;
      r_pad      <= '0;
      r_stride   <= '0;
      r_fmap_w   <= '0;
      r_fmap_h   <= '0;
      r_ch       <= '0;
      r_buf_w    <= '0;
      r_buf_d    <= '0;
      r_tile_row <= '0;
      r_tile_ch  <= '0;
      r_win_cnt  <= '0;
      r_cfg_err  <= 1'b0;
      r_aborted  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tile_row <= w_row_nxt;
      r_tile_ch  <= w_ch_nxt;
      r_cfg_err  <= w_accept & w_bad;
      if (w_take) begin
        r_kw       <= cfg_kw;
        r_kh       <= cfg_kh;
        r_pad      <= cfg_pad;
        r_stride   <= cfg_stride;
        r_fmap_w   <= cfg_fmap_w;
        r_fmap_h   <= cfg_fmap_h;
        r_ch       <= cfg_ch;
        r_tile_row <= '0;
        r_tile_ch  <= '0;
        r_win_cnt  <= '0;
      end else if (w_win_inc) begin
        r_win_cnt <= r_win_cnt + NW'(1);
      end
      // An abort during RUN/DRAIN still passes through FIN; remember it to skip NEXT.
      if ((r_state == SCHED_RUN || r_state == SCHED_DRAIN) && abort)
        r_aborted <= 1'b1;
      else if (r_state == SCHED_FIN)
        r_aborted <= 1'b0;
      if (w_state_nxt == SCHED_START && r_state != SCHED_START) begin
        r_buf_d <= tile_depth(r_fmap_h, w_row_nxt);
        r_buf_w <= r_fmap_w;
      end
    end
  end

  assign cfg_ready       = (r_state == SCHED_IDLE);
  assign busy            = (r_state != SCHED_IDLE);
  assign buf_req         = (r_state == SCHED_START);
  assign buf_req_final   = (r_state == SCHED_FIN);
  assign done            = (r_state == SCHED_DONE);
  assign cfg_err         = r_cfg_err;
  assign kernel_width_o  = r_kw;
  assign kernel_height_o = r_kh;
  assign stride_o        = r_stride;
  assign padding_o       = r_pad;
  assign buffer_width_o  = r_buf_w;
  assign buffer_depth_o  = r_buf_d;
  assign tile_row_o      = r_tile_row[HW-1:0];
  assign tile_ch_o       = r_tile_ch;
  assign win_cnt         = r_win_cnt;
  assign dbg_state       = r_state;

endmodule
